// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: 8-bit Fibonacci polynomial (taps 8,6,5,4), next-state function
// and checker state encoding. Used by both the generator and the checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ^(x & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational one-step LFSR predictor: nxt = lfsr_next(cur).
module lfsr_predict
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  always_comb begin
    nxt = lfsr_next(cur);
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR sequence checker: self-synchronises, flags and counts broken words.
// Optional LFSR_CHK_STATS_EN adds the word_count port and counter.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              valid_in,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
`ifdef LFSR_CHK_STATS_EN
  ,
  output logic [31:0]       word_count
`endif
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [LFSR_W-1:0] seed_nxt, run_nxt;
  logic [3:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic              locked_d, err_pulse_d, err_inc;
  logic [ERR_W-1:0]  err_d;

  lfsr_predict u_seed (.cur(data_in), .nxt(seed_nxt));
  lfsr_predict u_run  (.cur(exp_q),   .nxt(run_nxt));

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    if (valid_in) begin
      unique case (state_q)
        SEARCH: begin
          if (data_in != '0) begin
            exp_d   = seed_nxt;
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (data_in == exp_q) begin
            exp_d   = seed_nxt;
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
            if (data_in == '0) state_d = SEARCH;
            else               exp_d   = seed_nxt;
          end
        end
        LOCKED: begin
          // Free-run from the model so a burst of bad words cannot corrupt the prediction
          exp_d = run_nxt;
          if (data_in == exp_q) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOSS_N) state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);

    err_d = err_count;
    if (clear_cnt)                         err_d = '0;
    else if (err_inc && (err_count != '1)) err_d = err_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= SEARCH;
      exp_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_count <= err_d;
    end
  end

`ifdef LFSR_CHK_STATS_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      word_count <= '0;
    end else if (clear_cnt) begin
      word_count <= '0;
    end else if (valid_in && (word_count != '1)) begin
      word_count <= word_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised and directed bench for lfsr_checker against a sequence-table reference model.
// Honours LFSR_CHK_STATS_EN for the word_count port.
module tb_lfsr_checker;

  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 3;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        clear_cnt;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err16;
  logic [3:0]  err4;
`ifdef LFSR_CHK_STATS_EN
  logic [31:0] wc16, wc4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the full 255-entry sequence plus an inverse lookup
  int seq[255];
  int pos_of[256];
  int gi;
  int m_locked, m_synced, m_idx, m_run, m_miss, m_errs, m_pulse, m_words;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(16)) dut (
    .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .data_in(data_in), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err16)
`ifdef LFSR_CHK_STATS_EN
    , .word_count(wc16)
`endif
  );

  lfsr_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(4)) dut4 (
    .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .data_in(data_in), .clear_cnt(clear_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err4)
`ifdef LFSR_CHK_STATS_EN
    , .word_count(wc4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic mdl_reset();
    m_locked = 0; m_synced = 0; m_idx = 0; m_run = 0;
    m_miss = 0; m_errs = 0; m_pulse = 0; m_words = 0;
  endtask

  task automatic mdl_step(input logic v, input logic [7:0] d, input logic clr);
    int w;
    w = int'(d);
    m_pulse = 0;
    if (v) begin
      m_words++;
      if (m_locked != 0) begin
        if (w != seq[m_idx]) begin
          m_pulse = 1;
          m_errs++;
          m_miss++;
          if (m_miss == LOSS_COUNT) begin
            m_locked = 0;
            m_synced = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_idx = (m_idx + 1) % 255;
      end else if (m_synced == 0) begin
        if (w != 0) begin
          m_idx = (pos_of[w] + 1) % 255;
          m_run = 0;
          m_synced = 1;
        end
      end else if (w == seq[m_idx]) begin
        m_run++;
        m_idx = (m_idx + 1) % 255;
        if (m_run == LOCK_COUNT) begin
          m_locked = 1;
          m_miss = 0;
        end
      end else if (w == 0) begin
        m_synced = 0;
        m_run = 0;
      end else begin
        m_idx = (pos_of[w] + 1) % 255;
        m_run = 0;
      end
    end
    if (clr) begin
      m_errs = 0;
      m_words = 0;
    end
  endtask

  task automatic check_all();
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check_eq("err_count", 32'(err16), 32'(sat(m_errs, 65535)));
    check_eq("locked_w4", 32'(locked4), 32'(m_locked));
    check_eq("err_pulse_w4", 32'(err_pulse4), 32'(m_pulse));
    check_eq("err_count_w4", 32'(err4), 32'(sat(m_errs, 15)));
`ifdef LFSR_CHK_STATS_EN
    check_eq("word_count", wc16, 32'(m_words));
    check_eq("word_count_w4", wc4, 32'(m_words));
`endif
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic clr);
    @(negedge clk);
    valid_in = v; data_in = d; clear_cnt = clr;
    @(posedge clk);
    mdl_step(v, d, clr);
    #1;
    check_all();
  endtask

  task automatic send_good();
    drive(1'b1, 8'(seq[gi]), 1'b0);
    gi = (gi + 1) % 255;
  endtask

  task automatic send_bad();
    drive(1'b1, 8'(seq[gi]) ^ 8'h5A, 1'b0);
    gi = (gi + 1) % 255;
  endtask

  initial begin
    int x, fb;
    x = 1;
    pos_of[0] = 0;
    for (int i = 0; i < 255; i++) begin
      seq[i] = x;
      pos_of[x] = i;
      fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
      x = ((x << 1) & 255) | fb;
    end

    rst_l = 1'b0; valid_in = 1'b0; data_in = '0; clear_cnt = 1'b0;
    mdl_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_l = 1'b1;

    // 1: 01,02,04,08,11 -> lock one cycle after the fifth word
    gi = 0;
    for (int i = 0; i < 5; i++) begin
      send_good();
      if (i == 3) check_eq("t1_not_yet_locked", 32'(locked), 32'd0);
    end
    check_eq("t1_locked", 32'(locked), 32'd1);
    check_eq("t1_err0", 32'(err16), 32'd0);

    // 2: FF in place of 23, then 47,8E,... keep matching
    drive(1'b1, 8'hFF, 1'b0);
    gi = (gi + 1) % 255;
    check_eq("t2_pulse", 32'(err_pulse), 32'd1);
    check_eq("t2_err1", 32'(err16), 32'd1);
    check_eq("t2_still_locked", 32'(locked), 32'd1);
    send_good();
    check_eq("t2_next_ok", 32'(err_pulse), 32'd0);
    for (int i = 0; i < 4; i++) send_good();
    check_eq("t2_err_hold", 32'(err16), 32'd1);

    // 3: three bad words drop lock, then 1+4 good words relock
    for (int i = 0; i < 3; i++) begin
      if (i == 2) check_eq("t3_locked_before", 32'(locked), 32'd1);
      send_bad();
    end
    check_eq("t3_unlocked", 32'(locked), 32'd0);
    check_eq("t3_err4", 32'(err16), 32'd4);
    for (int i = 0; i < 5; i++) send_good();
    check_eq("t3_relocked", 32'(locked), 32'd1);

    // 4: force SEARCH, zeros ignored, then 08,11,23,47,8E
    for (int i = 0; i < 3; i++) send_bad();
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h00, 1'b0);
    check_eq("t4_search", 32'(locked), 32'd0);
    gi = 3;
    for (int i = 0; i < 5; i++) send_good();
    check_eq("t4_locked", 32'(locked), 32'd1);

    // 5: 20 errors while holding lock; narrow counter saturates; clear beats increment
    for (int i = 0; i < 10; i++) begin
      send_bad();
      send_bad();
      send_good();
    end
    check_eq("t5_sat4", 32'(err4), 32'hF);
    drive(1'b1, 8'(seq[gi]) ^ 8'h33, 1'b1);
    gi = (gi + 1) % 255;
    check_eq("t5_clr_pulse", 32'(err_pulse), 32'd1);
    check_eq("t5_clr_zero", 32'(err4), 32'd0);

    // 6: async reset mid-LOCKED
    send_good();
    send_bad();
    send_good();
    @(negedge clk);
    valid_in = 1'b0;
    #2 rst_l = 1'b0;
    mdl_reset();
    #1;
    check_eq("t6_rst_locked", 32'(locked), 32'd0);
    check_eq("t6_rst_err", 32'(err16), 32'd0);
    #1 rst_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_good();
      if (i == 3) check_eq("t6_relock_early", 32'(locked), 32'd0);
    end
    check_eq("t6_relock", 32'(locked), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) drive(1'b0, 8'(seq[gi]), 1'b0);
      send_good();
    end
`ifdef LFSR_CHK_STATS_EN
    check_eq("t6_word_count", wc16, 32'd10);
`endif

    // Random mix: mostly good words, some corruption, gaps and clears
    for (int i = 0; i < 600; i++) begin
      logic       v, c;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 40) == 0);
      d = ($urandom_range(0, 9) < 8) ? 8'(seq[gi]) : 8'($urandom);
      if ($urandom_range(0, 60) == 0) d = 8'h00;
      drive(v, d, c);
      if (v) gi = (gi + 1) % 255;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
